toy_cpu_core: RTL and testbench
===============================

# toy_cpu_core

Parametrised successor to the single-cycle opcode decoder: a two-stage, in-order toy processor core that executes one instruction per clock from the op bus, holding operands in a register file, computing in an ALU and driving a registered output port. Sits directly behind the instruction source of the user design; every cycle with `op_valid` high is one accepted instruction, with no back-pressure.

## Interface
- `DATA_W`, 8, datapath, register, immediate and output width (≥ 2)
- `NUM_REGS`, 8, register file depth (power of two, ≥ 2); `REG_AW = $clog2(NUM_REGS)` is derived, not overridable

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op_valid`  in  1  instruction present this cycle
- `opcode`  in  3  operation select
- `src_a`  in  REG_AW  first operand register
- `src_b`  in  REG_AW  second operand register
- `dest`  in  REG_AW  destination register
- `imm`  in  DATA_W  immediate operand
- `out`  out  DATA_W  output port register
- `out_valid`  out  1  one-cycle pulse when `out` updated
- `flag_z`  out  1  zero flag of last flag-setting op
- `flag_c`  out  1  carry/borrow flag of last ADD/SUB

## Operation
- Opcodes: 000 NOP; 001 LDI rd=imm; 010 ADD rd=ra+rb; 011 SUB rd=ra-rb; 100 AND; 101 OR; 110 XOR; 111 OUT out=ra.
- r0 reads as 0 always; writes to r0 discarded (flags still update).
- Arithmetic modulo 2^DATA_W. ADD: `flag_c` = carry out of bit DATA_W-1. SUB: `flag_c` = 1 when ra < rb unsigned (borrow).
- `flag_z` = (result == 0) for LDI, ADD, SUB, AND, OR, XOR. `flag_c` updated only by ADD/SUB, held otherwise. NOP and OUT touch neither flag.
- OUT: `out` loads ra value, `out_valid` pulses; `out` holds until next OUT. No register write.
- `op_valid` low: instruction fields ignored, bubble enters pipeline.
- Reset: all registers 0, `out`=0, `out_valid`=0, `flag_z`=0, `flag_c`=0, both stage valids 0. Reset asserted mid-stream discards any in-flight instruction (no write, no OUT pulse).

## Timing
- Stage 1 (RD), cycle N: fields sampled with `op_valid`; ra/rb read from register file; captured into EX registers at end of N.
- Stage 2 (EX/WB), cycle N+1: ALU evaluates; register write, flags, `out`, `out_valid` update at end of N+1. Results visible on outputs from cycle N+2.
- Bypass: if RD instruction in cycle N+1 reads a register written by the EX instruction in the same cycle, it takes the ALU result combinationally. Back-to-back dependent ops need no bubble.
- Bypass ignored when EX dest is r0, EX op is NOP/OUT, or EX stage invalid.
- Throughput one instruction per cycle; no stall or ready signal.
- `out_valid` high exactly one cycle per OUT; consecutive OUTs give consecutive pulses.

## Structure
- Package `toy_cpu_pkg`: opcode localparams (`OP_NOP` .. `OP_OUT`), opcode width 3.
- Sub-module `toy_cpu_alu`: purely combinational, ports opcode, a, b, imm → result, carry, zero, writes_reg; parametrised by `DATA_W`.
- Register file, bypass mux, pipeline registers and output registers in `toy_cpu_core`.

## Test plan
- Reset then LDI r1=0x05, LDI r2=0x03, ADD r3=r1+r2, OUT r3 back-to-back → `out`=0x08 with `out_valid` pulse 2 cycles after OUT accepted; `flag_z`=0, `flag_c`=0.
- LDI r1=0xFF, LDI r2=0x01, ADD r3 → `flag_c`=1, `flag_z`=1; SUB r4=r2-r1 → 0x02, `flag_c`=1; OUT r4 → 0x02.
- LDI r0=0x55, OUT r0 → `out`=0x00; `flag_z`=0 after LDI (result 0x55 nonzero) despite discarded write.
- Dependency chain with `op_valid` gaps of 0, 1, 2 bubbles between LDI r1=0xA5 and XOR r2=r1^r1 then OUT r1 → `out`=0xA5 and `flag_z`=1 in every case (bypass and register-file path agree).
- Assert `rst` the cycle after issuing LDI r1=0x77 and OUT r1 → no `out_valid`, `out`=0, subsequent OUT r1 → 0x00.
- DATA_W=16, NUM_REGS=16: LDI r15=0xFFFF, LDI r14=0x0001, ADD r13, OUT r13 → `out`=0x0000, `flag_c`=1, `flag_z`=1.

Source files
------------

// File: rtl/toy_cpu_pkg.sv
// Shared opcode encoding and helpers for the two-stage toy processor core.
// Imported by the ALU and the core top.
package toy_cpu_pkg;

   localparam int unsigned OPCODE_W = 3;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t OP_NOP = 3'b000;
   localparam opcode_t OP_LDI = 3'b001;
   localparam opcode_t OP_ADD = 3'b010;
   localparam opcode_t OP_SUB = 3'b011;
   localparam opcode_t OP_AND = 3'b100;
   localparam opcode_t OP_OR  = 3'b101;
   localparam opcode_t OP_XOR = 3'b110;
   localparam opcode_t OP_OUT = 3'b111;

   function automatic logic op_sets_carry(input opcode_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/toy_cpu_alu.sv
// Combinational ALU for the toy core: computes the result, carry/borrow and zero
// flags, and whether the opcode produces a register result.
module toy_cpu_alu
   import toy_cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  opcode_t           opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero,
   output logic              writes_reg
);

   always_comb begin
      result     = '0;
      carry      = 1'b0;
      writes_reg = 1'b1;
      unique case (opcode)
         OP_LDI: result = imm;
         OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         default: writes_reg = 1'b0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/toy_cpu_core.sv
// Two-stage in-order toy core: RD stage reads the register file (with EX bypass),
// EX/WB stage runs the ALU and commits register, flag and output-port updates.
module toy_cpu_core
   import toy_cpu_pkg::*;
#(
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned NUM_REGS = 8,
   localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_AW-1:0]   src_a,
   input  logic [REG_AW-1:0]   src_b,
   input  logic [REG_AW-1:0]   dest,
   input  logic [DATA_W-1:0]   imm,
   output logic [DATA_W-1:0]   out,
   output logic                out_valid,
   output logic                flag_z,
   output logic                flag_c
);

   logic              ex_valid_q, ex_valid_d;
   opcode_t           ex_op_q, ex_op_d;
   logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d;
   logic [DATA_W-1:0] ex_b_q, ex_b_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] rf_d [NUM_REGS];

   logic [DATA_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_c_q, flag_c_d;

   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic              alu_zero;
   logic              alu_writes;
   logic              wb_en;
   logic [DATA_W-1:0] rd_a, rd_b;

   toy_cpu_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .opcode    (ex_op_q),
      .a         (ex_a_q),
      .b         (ex_b_q),
      .imm       (ex_imm_q),
      .result    (alu_result),
      .carry     (alu_carry),
      .zero      (alu_zero),
      .writes_reg(alu_writes)
   );

   // One enable drives both the write port and the bypass so they can never disagree.
   assign wb_en = ex_valid_q && alu_writes && (ex_dest_q != '0);

   always_comb begin
      rd_a = rf_q[src_a];
      rd_b = rf_q[src_b];
      if (wb_en && (ex_dest_q == src_a)) rd_a = alu_result;
      if (wb_en && (ex_dest_q == src_b)) rd_b = alu_result;
      if (src_a == '0) rd_a = '0;
      if (src_b == '0) rd_b = '0;
   end

   always_comb begin
      ex_valid_d = op_valid;
      ex_op_d    = op_valid ? opcode_t'(opcode) : OP_NOP;
      ex_dest_d  = dest;
      ex_a_d     = rd_a;
      ex_b_d     = rd_b;
      ex_imm_d   = imm;

      rf_d = rf_q;
      if (wb_en) rf_d[ex_dest_q] = alu_result;

      flag_z_d    = flag_z_q;
      flag_c_d    = flag_c_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (ex_valid_q) begin
         if (alu_writes) flag_z_d = alu_zero;
         if (op_sets_carry(ex_op_q)) flag_c_d = alu_carry;
         if (ex_op_q == OP_OUT) begin
            out_d       = ex_a_q;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         ex_op_q     <= OP_NOP;
         ex_dest_q   <= '0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_imm_q    <= '0;
         rf_q        <= '{default: '0};
         out_q       <= '0;
         out_valid_q <= 1'b0;
         flag_z_q    <= 1'b0;
         flag_c_q    <= 1'b0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_op_q     <= ex_op_d;
         ex_dest_q   <= ex_dest_d;
         ex_a_q      <= ex_a_d;
         ex_b_q      <= ex_b_d;
         ex_imm_q    <= ex_imm_d;
         rf_q        <= rf_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         flag_z_q    <= flag_z_d;
         flag_c_q    <= flag_c_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_toy_cpu_core.sv
// Directed self-checking bench for toy_cpu_core: an 8-bit/8-register instance and a
// 16-bit/16-register instance driven from one linear stimulus sequence.
module tb_toy_cpu_core;
   import toy_cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   logic        v8;
   logic [2:0]  op8;
   logic [2:0]  a8, b8, d8;
   logic [7:0]  imm8;
   logic [7:0]  out8;
   logic        ov8, z8, c8;

   logic        v16;
   logic [2:0]  op16;
   logic [3:0]  a16, b16, d16;
   logic [15:0] imm16;
   logic [15:0] out16;
   logic        ov16, z16, c16;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   toy_cpu_core #(
      .DATA_W  (8),
      .NUM_REGS(8)
   ) dut8 (
      .clk      (clk),
      .rst      (rst),
      .op_valid (v8),
      .opcode   (op8),
      .src_a    (a8),
      .src_b    (b8),
      .dest     (d8),
      .imm      (imm8),
      .out      (out8),
      .out_valid(ov8),
      .flag_z   (z8),
      .flag_c   (c8)
   );

   toy_cpu_core #(
      .DATA_W  (16),
      .NUM_REGS(16)
   ) dut16 (
      .clk      (clk),
      .rst      (rst),
      .op_valid (v16),
      .opcode   (op16),
      .src_a    (a16),
      .src_b    (b16),
      .dest     (d16),
      .imm      (imm16),
      .out      (out16),
      .out_valid(ov16),
      .flag_z   (z16),
      .flag_c   (c16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic i8(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a,
                     input logic [2:0] b, input logic [7:0] im);
      v8 = 1'b1; op8 = op; d8 = d; a8 = a; b8 = b; imm8 = im;
      v16 = 1'b0;
      tick();
   endtask

   task automatic i16(input logic [2:0] op, input logic [3:0] d, input logic [3:0] a,
                      input logic [3:0] b, input logic [15:0] im);
      v16 = 1'b1; op16 = op; d16 = d; a16 = a; b16 = b; imm16 = im;
      v8 = 1'b0;
      tick();
   endtask

   // Bubble: fields set to junk to show they are ignored when op_valid is low.
   task automatic bubble();
      v8 = 1'b0; op8 = OP_LDI; d8 = 3'd1; a8 = 3'd1; b8 = 3'd1; imm8 = 8'hEE;
      v16 = 1'b0; op16 = OP_LDI; d16 = 4'd1; a16 = 4'd1; b16 = 4'd1; imm16 = 16'hEEEE;
      tick();
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      bubble();
      bubble();
      rst = 1'b0;
      check("reset_out8", out8, 16'h0000);
      check("reset_ov8", ov8, 16'h0);
      check("reset_z8", z8, 16'h0);
      check("reset_c8", c8, 16'h0);
      check("reset_ov16", ov16, 16'h0);

      // Back-to-back dependent chain exercising both bypass operands.
      i8(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05);
      i8(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h03);
      i8(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
      i8(OP_OUT, 3'd0, 3'd3, 3'd0, 8'h00);
      check("t1_no_early_pulse", ov8, 16'h0);
      bubble();
      check("t1_out", out8, 16'h0008);
      check("t1_ov", ov8, 16'h1);
      check("t1_z", z8, 16'h0);
      check("t1_c", c8, 16'h0);
      bubble();
      check("t1_ov_drop", ov8, 16'h0);
      check("t1_out_hold", out8, 16'h0008);

      // Carry-out with zero result, then borrow.
      i8(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hFF);
      i8(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01);
      i8(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
      i8(OP_SUB, 3'd4, 3'd2, 3'd1, 8'h00);
      check("t2_add_c", c8, 16'h1);
      check("t2_add_z", z8, 16'h1);
      i8(OP_OUT, 3'd0, 3'd4, 3'd0, 8'h00);
      check("t2_sub_c", c8, 16'h1);
      check("t2_sub_z", z8, 16'h0);
      bubble();
      check("t2_out", out8, 16'h0002);
      check("t2_ov", ov8, 16'h1);

      // r0 write discarded, flag_z still follows the LDI result.
      i8(OP_LDI, 3'd5, 3'd0, 3'd0, 8'h00);
      i8(OP_LDI, 3'd0, 3'd0, 3'd0, 8'h55);
      check("t3_z_set", z8, 16'h1);
      i8(OP_OUT, 3'd0, 3'd0, 3'd0, 8'h00);
      check("t3_z_ldi_r0", z8, 16'h0);
      bubble();
      check("t3_out_r0", out8, 16'h0000);
      check("t3_ov", ov8, 16'h1);

      for (int g = 0; g < 3; g++) begin
         i8(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h11);
         i8(OP_OUT, 3'd0, 3'd0, 3'd0, 8'h00);
         i8(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hA5);
         for (int k = 0; k < g; k++) bubble();
         i8(OP_XOR, 3'd2, 3'd1, 3'd1, 8'h00);
         i8(OP_OUT, 3'd0, 3'd1, 3'd0, 8'h00);
         check($sformatf("t4_gap%0d_z", g), z8, 16'h1);
         bubble();
         check($sformatf("t4_gap%0d_out", g), out8, 16'h00A5);
         check($sformatf("t4_gap%0d_ov", g), ov8, 16'h1);
      end

      // Reset while an OUT sits in EX: it must be discarded.
      i8(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h77);
      i8(OP_OUT, 3'd0, 3'd1, 3'd0, 8'h00);
      rst = 1'b1;
      bubble();
      rst = 1'b0;
      check("t5_ov_rst", ov8, 16'h0);
      check("t5_out_rst", out8, 16'h0000);
      check("t5_z_rst", z8, 16'h0);
      bubble();
      check("t5_ov_after", ov8, 16'h0);
      i8(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h3C);
      i8(OP_OUT, 3'd0, 3'd2, 3'd0, 8'h00);
      bubble();
      check("t5_out_r2", out8, 16'h003C);
      i8(OP_OUT, 3'd0, 3'd1, 3'd0, 8'h00);
      bubble();
      check("t5_out_r1_cleared", out8, 16'h0000);
      check("t5_ov_r1", ov8, 16'h1);

      // Wide instance with 16 registers.
      i16(OP_LDI, 4'd12, 4'd0, 4'd0, 16'h1234);
      i16(OP_OUT, 4'd0, 4'd12, 4'd0, 16'h0000);
      bubble();
      check("t6_out_1234", out16, 16'h1234);
      i16(OP_LDI, 4'd15, 4'd0, 4'd0, 16'hFFFF);
      i16(OP_LDI, 4'd14, 4'd0, 4'd0, 16'h0001);
      i16(OP_ADD, 4'd13, 4'd15, 4'd14, 16'h0000);
      i16(OP_OUT, 4'd0, 4'd13, 4'd0, 16'h0000);
      bubble();
      check("t6_out", out16, 16'h0000);
      check("t6_ov", ov16, 16'h1);
      check("t6_c", c16, 16'h1);
      check("t6_z", z16, 16'h1);
      bubble();
      check("t6_ov_drop", ov16, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
